model_buffer_server: RTL

//  Responder side of the render-pipeline model-data fetch interface. Stores vertex and index

---
 rtl/model_buffer_server.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/model_buffer_server.sv
// Model-data responder for render_pipeline: vertex/index RAM streams and the per-object MVP matrix.
// One model_buffer_stream instance per stream; each owns its RAM, its read pointer and its FSM.

module model_buffer_stream #(
   parameter int unsigned WIDTH = 72,
   parameter int unsigned DEPTH = 1024
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       start,
   input  logic [$clog2(DEPTH)-1:0]   base,
   input  logic [$clog2(DEPTH):0]     count,
   input  logic                       read_en,
   output logic [WIDTH-1:0]           data,
   output logic                       dv,
   output logic                       last,
   output logic                       active_c,
   output logic                       stream_nxt_c
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [AW-1:0]    addr_q, addr_nxt;
   logic [CW-1:0]    offset_q, offset_nxt, count_q;
   logic             issue_c, last_c;
   logic [WIDTH-1:0] mem [DEPTH];

   // Start overrides everything, including a read requested in the same cycle.
   always_comb begin
      state_nxt  = state;
      addr_nxt   = addr_q;
      offset_nxt = offset_q;
      issue_c    = 1'b0;
      last_c     = 1'b0;
      if (start) begin
         state_nxt  = (count != '0) ? S_STREAM : S_DONE;
         addr_nxt   = base;
         offset_nxt = '0;
      end else begin
         case (state)
            S_STREAM: begin
               if (read_en) begin
                  issue_c    = 1'b1;
                  addr_nxt   = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                  offset_nxt = offset_q + CW'(1);
                  if (offset_q == count_q - CW'(1)) begin
                     last_c    = 1'b1;
                     state_nxt = S_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         offset_q <= '0;
         count_q  <= '0;
         dv       <= 1'b0;
         last     <= 1'b0;
         data     <= '0;
      end else begin
         state    <= state_nxt;
         addr_q   <= addr_nxt;
         offset_q <= offset_nxt;
         if (start) count_q <= count;
         dv       <= issue_c;
         last     <= last_c;
         if (issue_c) data <= mem[addr_q];
      end
   end

   // Storage RAM; a same-cycle write to the read address is seen on the next read only.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign active_c     = (state != S_IDLE);
   assign stream_nxt_c = (state_nxt == S_STREAM);
endmodule

module model_buffer_server #(
   parameter int unsigned DATAWIDTH    = 24,
   parameter int unsigned IDXWIDTH     = 15,
   parameter int unsigned VERTEX_DEPTH = 1024,
   parameter int unsigned INDEX_DEPTH  = 1024
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            i_vert_wr_en,
   input  logic [$clog2(VERTEX_DEPTH)-1:0] i_vert_wr_addr,
   input  logic [3*DATAWIDTH-1:0]          i_vert_wr_data,
   input  logic                            i_idx_wr_en,
   input  logic [$clog2(INDEX_DEPTH)-1:0]  i_idx_wr_addr,
   input  logic [3*IDXWIDTH-1:0]           i_idx_wr_data,
   input  logic                            i_obj_start,
   input  logic [16*DATAWIDTH-1:0]         i_obj_mvp,
   input  logic [$clog2(VERTEX_DEPTH)-1:0] i_obj_vert_base,
   input  logic [$clog2(VERTEX_DEPTH):0]   i_obj_vert_count,
   input  logic [$clog2(INDEX_DEPTH)-1:0]  i_obj_idx_base,
   input  logic [$clog2(INDEX_DEPTH):0]    i_obj_idx_count,
   output logic                            o_ready,
   input  logic                            i_mvp_read_en,
   output logic [16*DATAWIDTH-1:0]         o_mvp,
   output logic                            o_mvp_dv,
   input  logic                            i_vertex_read_en,
   output logic [3*DATAWIDTH-1:0]          o_vertex,
   output logic                            o_vertex_dv,
   output logic                            o_vertex_last,
   input  logic                            i_index_read_en,
   output logic [3*IDXWIDTH-1:0]           o_index,
   output logic                            o_index_dv,
   output logic                            o_index_last
);
   logic v_active_c, i_active_c, v_stream_nxt_c, i_stream_nxt_c;

   model_buffer_stream #(.WIDTH(3*DATAWIDTH), .DEPTH(VERTEX_DEPTH)) u_vert (
      .clk(clk), .rstn(rstn),
      .wr_en(i_vert_wr_en), .wr_addr(i_vert_wr_addr), .wr_data(i_vert_wr_data),
      .start(i_obj_start), .base(i_obj_vert_base), .count(i_obj_vert_count),
      .read_en(i_vertex_read_en), .data(o_vertex), .dv(o_vertex_dv), .last(o_vertex_last),
      .active_c(v_active_c), .stream_nxt_c(v_stream_nxt_c)
   );

   model_buffer_stream #(.WIDTH(3*IDXWIDTH), .DEPTH(INDEX_DEPTH)) u_idx (
      .clk(clk), .rstn(rstn),
      .wr_en(i_idx_wr_en), .wr_addr(i_idx_wr_addr), .wr_data(i_idx_wr_data),
      .start(i_obj_start), .base(i_obj_idx_base), .count(i_obj_idx_count),
      .read_en(i_index_read_en), .data(o_index), .dv(o_index_dv), .last(o_index_last),
      .active_c(i_active_c), .stream_nxt_c(i_stream_nxt_c)
   );

   // MVP is answerable once any object has been started since reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_mvp    <= '0;
         o_mvp_dv <= 1'b0;
         o_ready  <= 1'b1;
      end else begin
         if (i_obj_start) o_mvp <= i_obj_mvp;
         o_mvp_dv <= i_mvp_read_en && (v_active_c || i_active_c);
         o_ready  <= !(v_stream_nxt_c || i_stream_nxt_c);
      end
   end
endmodule
